// File: rtl/sdram_cmd_arbiter_if.sv
// sdram_cmd_arbiter_if: request, SDRAM-controller and cache/video data-path signals of the arbiter.
// Latency: none; this is only a signal bundle.
// Backpressure: the controller paces the arbiter with sys_cmd_ack and the per-beat valid strobes.
interface sdram_cmd_arbiter_if;
  // requesters
  logic        vid_low;
  logic        cache_wr_req;
  logic        cache_rd_req;
  logic [16:0] cache_wr_addr;
  logic [16:0] cache_rd_addr;
  // SDRAM controller side
  logic [1:0]  sys_cmd;
  logic [22:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid;
  logic        sys_wr_data_valid;
  logic [15:0] sys_dout;
  // cache / video data path and status
  logic        cache_wdata_en;
  logic        cache_rdata_en;
  logic        vid_we;
  logic [31:0] vid_data;
  logic        cache_done;
  logic        busy;

  // arbiter side
  modport master (
    input  vid_low, cache_wr_req, cache_rd_req, cache_wr_addr, cache_rd_addr,
    input  sys_cmd_ack, sys_rd_data_valid, sys_wr_data_valid, sys_dout,
    output sys_cmd, sys_addr, cache_wdata_en, cache_rdata_en, vid_we, vid_data,
    output cache_done, busy
  );

  // requesters, controller and data sinks
  modport slave (
    output vid_low, cache_wr_req, cache_rd_req, cache_wr_addr, cache_rd_addr,
    output sys_cmd_ack, sys_rd_data_valid, sys_wr_data_valid, sys_dout,
    input  sys_cmd, sys_addr, cache_wdata_en, cache_rdata_en, vid_we, vid_data,
    input  cache_done, busy
  );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: arbitrates video refill and cache write-back/line-fill onto one SDRAM command port.
// Latency: grant edge -> sys_cmd valid 1 cycle; last beat -> cache_done 1 cycle; video pair -> vid_we 1 cycle.
// Backpressure: sys_cmd held until acked; beats advance only on controller strobes. Optional ARB_STARVE_GUARD_EN.
module sdram_cmd_arbiter #(
  parameter int unsigned VID_LAST   = 19199,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  sdram_cmd_arbiter_if.master bus
);

  localparam logic [1:0]  CMD_NOP    = 2'b00;
  localparam logic [1:0]  CMD_WR256  = 2'b01;
  localparam logic [1:0]  CMD_RD32   = 2'b10;
  localparam logic [1:0]  CMD_RD256  = 2'b11;
  localparam logic [6:0]  VID_BEAT_LAST   = 7'd15;
  localparam logic [6:0]  CACHE_BEAT_LAST = 7'd127;
  localparam logic [18:0] VID_ADR_LAST    = 19'(VID_LAST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [1:0]  sys_cmd_q;     // command on the controller port; drops to NOP once acked
  logic [1:0]  op_cmd_q;      // command of the operation in flight, kept for the burst
  logic [22:0] sys_addr_q;
  logic [18:0] vid_adr_q;     // next video block to fetch
  logic [6:0]  beat_q;        // beats seen so far in the current burst
  logic        pair_q;        // 1 when the low halfword of a video pair is held
  logic [15:0] vid_low_half_q;
  logic [31:0] vid_data_q;
  logic        vid_we_q;
  logic        cache_done_q;

  logic        cache_pend;
  logic [1:0]  cache_cmd;
  logic        starve_force;
  logic [1:0]  grant_cmd;
  logic [22:0] grant_addr;
  logic        ack_hit;
  logic        beat_hit;
  logic        last_beat;
  logic        vid_beat;

  assign cache_pend = bus.cache_wr_req | bus.cache_rd_req;
  // write-back outranks line-fill so dirty data leaves before a fill can reuse the line
  assign cache_cmd  = bus.cache_wr_req ? CMD_WR256 : CMD_RD256;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_q;       // consecutive video grants while the cache waited

  // Starvation count: advances on video grants that bypass a waiting cache request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 3'd0;
    end else if (state_q == IDLE) begin
      if (!cache_pend || grant_cmd == CMD_WR256 || grant_cmd == CMD_RD256) begin
        starve_q <= 3'd0;
      end else if (grant_cmd == CMD_RD32) begin
        starve_q <= starve_q + 3'd1;
      end
    end
  end

  assign starve_force = cache_pend && (starve_q == 3'(STARVE_MAX));
`else
  assign starve_force = 1'b0;
`endif

  // Next-state and per-cycle decode: grant in IDLE, ack match in ISSUE, beat counting in BURST
  always_comb begin
    state_d    = state_q;
    grant_cmd  = CMD_NOP;
    grant_addr = 23'd0;
    ack_hit    = 1'b0;
    beat_hit   = 1'b0;
    last_beat  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.vid_low && !starve_force) begin
          grant_cmd = CMD_RD32;
        end else if (cache_pend) begin
          grant_cmd = cache_cmd;
        end
        case (grant_cmd)
          CMD_WR256: grant_addr = {bus.cache_wr_addr, 6'b000000};
          CMD_RD32:  grant_addr = {1'b1, vid_adr_q, 3'b000};
          CMD_RD256: grant_addr = {bus.cache_rd_addr, 6'b000000};
          default:   grant_addr = 23'd0;
        endcase
        if (grant_cmd != CMD_NOP) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.sys_cmd_ack == op_cmd_q) begin
          ack_hit = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        beat_hit  = (op_cmd_q == CMD_WR256) ? bus.sys_wr_data_valid : bus.sys_rd_data_valid;
        last_beat = beat_hit &&
                    (beat_q == ((op_cmd_q == CMD_RD32) ? VID_BEAT_LAST : CACHE_BEAT_LAST));
        if (last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vid_beat = beat_hit && (op_cmd_q == CMD_RD32);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command/address: latched at grant, command held until acked; address stays for the whole op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_cmd_q  <= CMD_NOP;
      op_cmd_q   <= CMD_NOP;
      sys_addr_q <= 23'd0;
    end else if (state_q == IDLE && grant_cmd != CMD_NOP) begin
      sys_cmd_q  <= grant_cmd;
      op_cmd_q   <= grant_cmd;
      sys_addr_q <= grant_addr;
    end else if (ack_hit) begin
      sys_cmd_q  <= CMD_NOP;
    end
  end

  // Video block pointer: advances once per accepted video command, wrapping at the frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vid_adr_q <= 19'd0;
    end else if (ack_hit && op_cmd_q == CMD_RD32) begin
      vid_adr_q <= (vid_adr_q == VID_ADR_LAST) ? 19'd0 : vid_adr_q + 19'd1;
    end
  end

  // Beat counter: counts only the strobe that belongs to the command in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= 7'd0;
    end else if (ack_hit) begin
      beat_q <= 7'd0;
    end else if (beat_hit) begin
      beat_q <= last_beat ? 7'd0 : beat_q + 7'd1;
    end
  end

  // Video pairing: first halfword of a pair is parked, second one completes the 32-bit word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_q         <= 1'b0;
      vid_low_half_q <= 16'd0;
      vid_data_q     <= 32'd0;
      vid_we_q       <= 1'b0;
    end else begin
      vid_we_q <= vid_beat && pair_q;
      if (vid_beat) begin
        pair_q <= ~pair_q;
        if (!pair_q) begin
          vid_low_half_q <= bus.sys_dout;
        end else begin
          vid_data_q <= {bus.sys_dout, vid_low_half_q};
        end
      end
    end
  end

  // Completion pulse for cache operations only; video refills complete silently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_done_q <= 1'b0;
    end else begin
      cache_done_q <= last_beat && (op_cmd_q != CMD_RD32);
    end
  end

  assign bus.sys_cmd        = sys_cmd_q;
  assign bus.sys_addr       = sys_addr_q;
  assign bus.vid_we         = vid_we_q;
  assign bus.vid_data       = vid_data_q;
  assign bus.cache_done     = cache_done_q;
  assign bus.busy           = (state_q != IDLE);
  // the cache data strobes pass straight through so the cache sees the beat in the same cycle
  assign bus.cache_wdata_en = (state_q == BURST) && (op_cmd_q == CMD_RD256) && bus.sys_rd_data_valid;
  assign bus.cache_rdata_en = (state_q == BURST) && (op_cmd_q == CMD_WR256) && bus.sys_wr_data_valid;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb_sdram_cmd_arbiter: plays requesters and SDRAM controller around sdram_cmd_arbiter.
// Latency: expectations derived from a block-level model of grants, addresses and burst contents.
// Backpressure: randomized ack delays and beat gaps; wrong-type strobes and acks are injected.
`timescale 1ns/1ps
module tb_sdram_cmd_arbiter;

  // a short frame keeps the video wrap reachable within a few bursts
  localparam int VID_LAST_TB = 5;
  localparam int STARVE_TB   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_cmd_arbiter_if bus();

  sdram_cmd_arbiter #(.VID_LAST(VID_LAST_TB), .STARVE_MAX(STARVE_TB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // observation counters, sampled once per cycle well away from the rising edge
  int          n_we   = 0;
  int          n_done = 0;
  int          n_wen  = 0;
  int          n_ren  = 0;
  logic [31:0] we_log [1024];

  always @(negedge clk) begin
    #2;
    if (bus.vid_we === 1'b1) begin
      we_log[n_we % 1024] = bus.vid_data;
      n_we++;
    end
    if (bus.cache_done === 1'b1)     n_done++;
    if (bus.cache_wdata_en === 1'b1) n_wen++;
    if (bus.cache_rdata_en === 1'b1) n_ren++;
  end

  // reference model state: next video block and guard count
  int vid_blk = 0;
  int starve  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick();
    bit         cp;
    logic [1:0] cc;
    cp = bus.cache_wr_req || bus.cache_rd_req;
    cc = bus.cache_wr_req ? 2'b01 : 2'b11;
    if (!bus.vid_low && !cp) return 2'b00;
`ifdef ARB_STARVE_GUARD_EN
    if (bus.vid_low && cp && starve == STARVE_TB) return cc;
`endif
    if (bus.vid_low) return 2'b10;
    return cc;
  endfunction

  task automatic clear_reqs();
    bus.vid_low      = 1'b0;
    bus.cache_wr_req = 1'b0;
    bus.cache_rd_req = 1'b0;
  endtask

  // One complete operation from the requests currently driven. abort_at >= 0 pulls reset on that beat.
  task automatic run_op(input int abort_at, input bit drop);
    logic [1:0]  ec;
    logic [22:0] ea;
    logic [15:0] beats[$];
    logic [15:0] dat;
    bit          got, cp, is_vid;
    int          nb, d, we0, done0, wen0, ren0;
    ec = pick();
    cp = bus.cache_wr_req || bus.cache_rd_req;
    case (ec)
      2'b10:   ea = 23'(32'h400000 + vid_blk * 8);
      2'b01:   ea = 23'(int'(bus.cache_wr_addr) * 64);
      default: ea = 23'(int'(bus.cache_rd_addr) * 64);
    endcase
    is_vid = (ec == 2'b10);
    we0 = n_we; done0 = n_done; wen0 = n_wen; ren0 = n_ren;
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      got = (bus.sys_cmd !== 2'b00);
    end
    check("grant_seen", 64'(got), 64'(1));
    if (!got) return;
    check("sys_cmd", 64'(bus.sys_cmd), 64'(ec));
    check("sys_addr", 64'(bus.sys_addr), 64'(ea));
    check("busy_op", 64'(bus.busy), 64'(1));
    if (is_vid && cp) starve++; else starve = 0;
    if (drop) clear_reqs();
    // wrong acks and stray strobes while the command waits must not count
    d = $urandom_range(0, 3);
    repeat (d) begin
      bus.sys_cmd_ack       = ec ^ 2'b11;
      bus.sys_rd_data_valid = 1'($urandom_range(0, 1));
      bus.sys_wr_data_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.sys_rd_data_valid = 1'b0;
    bus.sys_wr_data_valid = 1'b0;
    check("cmd_held", 64'(bus.sys_cmd), 64'(ec));
    bus.sys_cmd_ack = ec;
    @(negedge clk);
    bus.sys_cmd_ack = 2'b00;
    check("cmd_cleared", 64'(bus.sys_cmd), 64'(0));
    if (is_vid) vid_blk = (vid_blk == VID_LAST_TB) ? 0 : vid_blk + 1;
    nb = is_vid ? 16 : 128;
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      dat = 16'($urandom);
      bus.sys_dout = dat;
      if (ec == 2'b01) begin
        bus.sys_wr_data_valid = 1'b1;
        bus.sys_rd_data_valid = 1'($urandom_range(0, 1));
      end else begin
        bus.sys_rd_data_valid = 1'b1;
        bus.sys_wr_data_valid = 1'($urandom_range(0, 1));
      end
      beats.push_back(dat);
      if (i == abort_at) begin
        bus.sys_rd_data_valid = 1'b1;
        rst = 1'b0;
        #1;
        check("abort_sys_cmd", 64'(bus.sys_cmd), 64'(0));
        check("abort_sys_addr", 64'(bus.sys_addr), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_wdata_en", 64'(bus.cache_wdata_en), 64'(0));
        check("abort_vid_data", 64'(bus.vid_data), 64'(0));
        check("abort_cache_done", 64'(bus.cache_done), 64'(0));
        bus.sys_rd_data_valid = 1'b0;
        bus.sys_wr_data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(n_done - done0), 64'(0));
        vid_blk = 0;
        starve  = 0;
        return;
      end
      @(negedge clk);
      bus.sys_rd_data_valid = 1'b0;
      bus.sys_wr_data_valid = 1'b0;
    end
    check("busy_end", 64'(bus.busy), 64'(0));
    check("cache_done_pulse", 64'(bus.cache_done), 64'(!is_vid));
    @(negedge clk);
    check("cache_done_low", 64'(bus.cache_done), 64'(0));
    check("vid_we_count", 64'(n_we - we0), 64'(is_vid ? 8 : 0));
    check("done_count", 64'(n_done - done0), 64'(is_vid ? 0 : 1));
    check("wdata_en_count", 64'(n_wen - wen0), 64'(ec == 2'b11 ? 128 : 0));
    check("rdata_en_count", 64'(n_ren - ren0), 64'(ec == 2'b01 ? 128 : 0));
    if (is_vid) begin
      for (int k = 0; k < 8; k++) begin
        check("vid_data", 64'(we_log[(we0 + k) % 1024]),
              64'(int'(beats[2*k+1]) * 65536 + int'(beats[2*k])));
      end
    end
    if (!(bus.cache_wr_req || bus.cache_rd_req)) starve = 0;
  endtask

  // Strobes and acks while idle must be ignored
  task automatic stray_idle();
    int we0, wen0, ren0;
    we0 = n_we; wen0 = n_wen; ren0 = n_ren;
    for (int i = 0; i < 4; i++) begin
      bus.sys_rd_data_valid = 1'b1;
      bus.sys_wr_data_valid = 1'(i % 2);
      bus.sys_cmd_ack       = 2'(i);
      bus.sys_dout          = 16'($urandom);
      #1;
      check("stray_wdata_en", 64'(bus.cache_wdata_en), 64'(0));
      @(negedge clk);
    end
    bus.sys_rd_data_valid = 1'b0;
    bus.sys_wr_data_valid = 1'b0;
    bus.sys_cmd_ack       = 2'b00;
    @(negedge clk);
    check("stray_busy", 64'(bus.busy), 64'(0));
    check("stray_sys_cmd", 64'(bus.sys_cmd), 64'(0));
    check("stray_vid_we", 64'(n_we - we0), 64'(0));
    check("stray_wen", 64'(n_wen - wen0), 64'(0));
    check("stray_ren", 64'(n_ren - ren0), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] r;
    clear_reqs();
    bus.cache_wr_addr     = 17'd0;
    bus.cache_rd_addr     = 17'd0;
    bus.sys_cmd_ack       = 2'b00;
    bus.sys_rd_data_valid = 1'b0;
    bus.sys_wr_data_valid = 1'b0;
    bus.sys_dout          = 16'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    // reset values, with requests and strobes active to show they are held off
    bus.vid_low = 1'b1;
    bus.sys_rd_data_valid = 1'b1;
    bus.sys_wr_data_valid = 1'b1;
    #1;
    check("rst_sys_cmd", 64'(bus.sys_cmd), 64'(0));
    check("rst_sys_addr", 64'(bus.sys_addr), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_vid_we", 64'(bus.vid_we), 64'(0));
    check("rst_vid_data", 64'(bus.vid_data), 64'(0));
    check("rst_cache_done", 64'(bus.cache_done), 64'(0));
    check("rst_wdata_en", 64'(bus.cache_wdata_en), 64'(0));
    check("rst_rdata_en", 64'(bus.cache_rdata_en), 64'(0));
    bus.vid_low = 1'b0;
    bus.sys_rd_data_valid = 1'b0;
    bus.sys_wr_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // first video refill, then the following block
    bus.vid_low = 1'b1;
    run_op(-1, 1'b1);
    bus.vid_low = 1'b1;
    run_op(-1, 1'b1);

    // write-back of line 0x12
    bus.cache_wr_addr = 17'h00012;
    bus.cache_wr_req  = 1'b1;
    run_op(-1, 1'b1);

    // idle strobes, then a video refill proves the block pointer did not move
    stray_idle();
    bus.vid_low = 1'b1;
    run_op(-1, 1'b1);

    // write-back outranks fill
    bus.cache_wr_addr = 17'($urandom);
    bus.cache_rd_addr = 17'($urandom);
    bus.cache_wr_req  = 1'b1;
    bus.cache_rd_req  = 1'b1;
    run_op(-1, 1'b1);

    // plain line fill
    bus.cache_rd_addr = 17'($urandom);
    bus.cache_rd_req  = 1'b1;
    run_op(-1, 1'b1);

    // reset in the middle of a fill, then a clean video refill from block 0
    bus.cache_rd_addr = 17'($urandom);
    bus.cache_rd_req  = 1'b1;
    run_op(60, 1'b1);
    bus.vid_low = 1'b1;
    run_op(-1, 1'b1);

    // video and fill held together
    bus.vid_low      = 1'b1;
    bus.cache_rd_req = 1'b1;
    for (int g = 0; g < 5; g++) run_op(-1, (g == 4));
    clear_reqs();
    repeat (2) @(negedge clk);

    // walk the video pointer through the end of the frame
    for (int g = 0; g < VID_LAST_TB + 2; g++) begin
      bus.vid_low = 1'b1;
      run_op(-1, 1'b1);
    end

    // random request mixes
    for (int g = 0; g < 6; g++) begin
      r = 3'($urandom_range(1, 7));
      bus.cache_wr_addr = 17'($urandom);
      bus.cache_rd_addr = 17'($urandom);
      bus.vid_low       = r[0];
      bus.cache_wr_req  = r[1];
      bus.cache_rd_req  = r[2];
      run_op(-1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
